// File: rtl/if_pkg.sv
// if_pkg: shared fetch-unit types and constants.
// The fetch entry carries the instruction word with its PC and PC+4.
package if_pkg;

    localparam int XLEN       = 32;
    localparam int INST_ALIGN = 4;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with flush and occupancy output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with in-flight tracking, redirect squash and fetch queue.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        IF_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int QW = $clog2(FQ_DEPTH) + 1;
    localparam int CW = $clog2(FQ_DEPTH + MAX_OUT) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] s_head;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   out_n;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_n;
    logic [QW-1:0]   q_cnt;
    logic [QW-1:0]   s_cnt;
    logic            q_empty;
    logic            s_empty;
    logic            redirect;
    logic            issue;
    logic            keep;
    logic            pop;
    fetch_entry_t    q_din;
    fetch_entry_t    q_dout;
    logic            unused_ok;

    assign redirect       = branch || jump;
    assign target         = align_pc(jump ? jalr_target : branch_target);
    assign IF_flush       = redirect;
    // Credit check counts in-flight requests so every response has a queue slot.
    assign imem_req_valid = rst && (out_cnt < CW'(MAX_OUT)) && ((CW'(q_cnt) + out_cnt) < CW'(FQ_DEPTH));
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign keep           = imem_rsp_valid && !redirect && (drop_cnt == '0);
    assign out_n          = out_cnt + CW'(issue) - CW'(imem_rsp_valid);
    assign drop_n         = redirect ? out_n : drop_cnt - CW'(imem_rsp_valid && (drop_cnt != '0));
    assign inst_valid     = !q_empty && !redirect;
    assign pop            = inst_valid && inst_ready;
    assign q_din          = '{inst: imem_rsp_data, pc: s_head, pc4: s_head + XLEN'(INST_ALIGN)};
    assign inst           = q_dout.inst;
    assign inst_pc        = q_dout.pc;
    assign inst_pc4       = q_dout.pc4;
    assign unused_ok      = &{1'b0, s_cnt, s_empty};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            pc_q     <= redirect ? target : issue ? pc_q + XLEN'(INST_ALIGN) : pc_q;
            out_cnt  <= out_n;
            drop_cnt <= drop_n;
        end
    end

    // Issued addresses; stale entries are cleared on redirect since their responses are dropped.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (keep),
        .flush (redirect),
        .din   (pc_q),
        .dout  (s_head),
        .empty (s_empty),
        .count (s_cnt)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .flush (redirect),
        .din   (q_din),
        .dout  (q_dout),
        .empty (q_empty),
        .count (q_cnt)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(keep);
            perf_flush_cnt <= perf_flush_cnt + 32'(redirect);
        end
    end
`endif

endmodule
